alu_serial_nb: RTL
==================

Name: alu_serial_nb

Overview:
- Parametrised, multi-cycle successor to the combinational 4-bit ALU.
- Adds, subtracts, compares or XORs two WIDTH-bit operands, DIGIT bits per cycle, LSB chunk first, with the carry/borrow held in a register between cycles.
- Valid/ready handshakes on input and output let it sit between register-sliced datapath stages.
- Trades latency for area on wide operands.

Parameters:
- WIDTH, 8, operand and result width; must be a multiple of DIGIT, otherwise elaboration fails.
- DIGIT, 4, bits processed per cycle; DIGIT = WIDTH gives single-cycle operation.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands and op valid.
- in_ready  out  1  block can accept a new operation.
- op  in  2  operation select: 00 ADD, 01 SUB, 10 CMP, 11 XOR.
- a  in  [0:WIDTH-1]  operand A; index 0 is the MSB.
- b  in  [0:WIDTH-1]  operand B; index 0 is the MSB.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- result  out  [0:WIDTH-1]  sum, difference or XOR.
- carry  out  1  ADD: carry-out; SUB/CMP: borrow-out (1 when a < b unsigned); XOR: 0.
- gt  out  1  a > b, unsigned.
- lt  out  1  a < b, unsigned.
- eq  out  1  a == b.

Behaviour:
- Reset (async, rst_n = 0): state IDLE; out_valid, result, carry, gt, lt, eq all 0; chunk counter 0. Any in-flight operation is discarded. in_ready = 1 while in reset and in IDLE.
- States:
  - IDLE: accepts on in_valid && in_ready, then goes to BUSY.
  - BUSY: counts NCHUNK = WIDTH/DIGIT cycles, then goes to DONE.
  - DONE: holds out_valid = 1 until out_ready.
- Acceptance: a, b and op are captured on the accepting edge. Carry register is 0 for ADD and 0 (no borrow) for SUB/CMP. Compare state (gt, lt) is cleared.
- Each BUSY cycle processes chunk k (k = 0 is the least-significant DIGIT bits):
  - ADD: chunk_a + chunk_b + c.
  - SUB/CMP: chunk_a - chunk_b - borrow.
  - XOR: bitwise XOR.
  - The chunk result is written into result[WIDTH-DIGIT*(k+1) : WIDTH-1-DIGIT*k]; the carry/borrow register is updated.
- Compare, LSB-first: if chunk_a != chunk_b, gt/lt are overwritten from this chunk; otherwise they are kept. eq = !gt && !lt, valid at DONE. Flags are computed for every op.
- CMP: result = a - b (same as SUB). Consumers use the flags.
- Latency: out_valid rises exactly NCHUNK cycles after the accepting edge. result, carry and flags are stable while out_valid = 1.
- DONE: transfer occurs on out_valid && out_ready. in_ready = out_ready in DONE, so a new operation may be accepted on the same edge as the transfer (back-to-back, one operation per NCHUNK+1 cycles). With no new in_valid, the block returns to IDLE and out_valid drops. Output fields hold their last values after the transfer.
- in_ready = 0 throughout BUSY; in_valid is ignored there.
- The block drives no X on outputs after reset.

Optional Feature:
- Macro: ALU_SAT_EN.
- Defined: saturating unsigned arithmetic at DONE. ADD with carry = 1 gives result all ones; SUB with borrow = 1 gives result all zeros. The carry and flags still report the raw outcome. CMP and XOR are unaffected.
- Undefined: modular wrap-around results, with no extra logic.

Decomposition:
- Package alu_pkg holds:
  - op_t enum (OP_ADD, OP_SUB, OP_CMP, OP_XOR);
  - state_t enum (S_IDLE, S_BUSY, S_DONE);
  - a localparam helper for NCHUNK and counter width $clog2(NCHUNK+1).
- Sub-module alu_digit_slice: combinational DIGIT-bit ripple add/sub with cin/cout, sub select, and chunk gt/lt outputs. It is instantiated once and reused across cycles.

Test Plan (WIDTH = 8, DIGIT = 4, latency 2):
- ADD a = 0xFF, b = 0x01, out_ready = 1 -> out_valid 2 cycles after accept. Without ALU_SAT_EN: result 0x00, carry 1, gt 1. With ALU_SAT_EN: result 0xFF.
- SUB a = 0x05, b = 0x09 -> result 0xFC, carry 1, lt 1, gt 0, eq 0. With ALU_SAT_EN: result 0x00.
- CMP a = 0x3C, b = 0x3C -> result 0x00, carry 0, eq 1. CMP a = 0x3C, b = 0x4B -> lt 1. This exercises the high-chunk decision overriding the low-chunk result.
- XOR a = 0xA5, b = 0x0F -> result 0xAA, carry 0, gt 1. Hold out_ready = 0 for 5 cycles -> outputs stable, in_ready 0, a second in_valid is not accepted.
- Back-to-back: ten random ops with in_valid and out_ready held at 1 -> one result every 3 cycles, all matching the reference model.
- Assert rst_n = 0 mid-BUSY -> out_valid, result and flags are 0 immediately (async). After release: in_ready 1, and the next op completes correctly.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared types and sizing helpers for the serial ALU.
package alu_pkg;
  typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB = 2'b01, OP_CMP = 2'b10, OP_XOR = 2'b11} op_t;
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
  function automatic int nchunk(input int width, input int digit);
    return width / digit;
  endfunction
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/alu_digit_slice.sv
// alu_digit_slice: combinational DIGIT-bit add/sub with carry chain and chunk compare.
// Ports: a, b chunk operands; cin carry (ADD) or borrow (SUB) in; sub selects subtract;
//        s chunk result; cout carry or borrow out; gt/lt unsigned chunk compare.
module alu_digit_slice #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic [DIGIT-1:0] s,
  output logic             cout,
  output logic             gt,
  output logic             lt
);
  logic [DIGIT:0] sum;
  // Subtract as a + ~b + !borrow; the adder carry is then the inverted borrow.
  assign sum  = {1'b0, a} + {1'b0, sub ? ~b : b} + {{DIGIT{1'b0}}, sub ^ cin};
  assign s    = sum[DIGIT-1:0];
  assign cout = sum[DIGIT] ^ sub;
  assign gt   = a > b;
  assign lt   = a < b;
endmodule

// File: rtl/alu_serial_nb.sv
// alu_serial_nb: multi-cycle ADD/SUB/CMP/XOR ALU processing DIGIT bits per cycle, LSB chunk first.
// Ports: clk, rst_n (async, active low); in_valid/in_ready accept op, a, b (index 0 = MSB);
//        out_valid/out_ready hand off result, carry (carry or borrow), gt, lt, eq.
// Build option: define ALU_SAT_EN for saturating unsigned ADD/SUB results.
module alu_serial_nb
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [0:WIDTH-1] a,
  input  logic [0:WIDTH-1] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [0:WIDTH-1] result,
  output logic             carry,
  output logic             gt,
  output logic             lt,
  output logic             eq
);
  localparam int NCHUNK = nchunk(WIDTH, DIGIT);
  localparam int CW = cnt_w(NCHUNK);
  if (WIDTH % DIGIT != 0) begin : g_bad_digit
    $error("WIDTH must be a multiple of DIGIT");
  end
  state_t           state_q, state_d;
  op_t              op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d, gt_q, gt_d, lt_q, lt_d, eq_q, eq_d;
  logic [DIGIT-1:0] ca, cb, cs;
  logic             cout, cgt, clt, acc, last;
  // Operands are held whole and the active chunk is picked by the counter.
  assign ca   = a_q[cnt_q*DIGIT +: DIGIT];
  assign cb   = b_q[cnt_q*DIGIT +: DIGIT];
  assign last = cnt_q == CW'(NCHUNK - 1);
  alu_digit_slice #(.DIGIT(DIGIT)) u_slice (
    .a   (ca),
    .b   (cb),
    .cin (carry_q),
    .sub (op_q != OP_ADD),
    .s   (cs),
    .cout(cout),
    .gt  (cgt),
    .lt  (clt)
  );
  assign in_ready  = state_q == S_IDLE || (state_q == S_DONE && out_ready);
  assign acc       = in_valid && in_ready;
  assign out_valid = state_q == S_DONE;
  assign result    = res_q;
  assign carry     = carry_q;
  assign gt        = gt_q;
  assign lt        = lt_q;
  assign eq        = eq_q;
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    gt_d    = gt_q;
    lt_d    = lt_q;
    eq_d    = eq_q;
    if (acc) begin
      state_d = S_BUSY;
      op_d    = op_t'(op);
      a_d     = a;
      b_d     = b;
      cnt_d   = '0;
      carry_d = 1'b0;
      gt_d    = 1'b0;
      lt_d    = 1'b0;
      eq_d    = 1'b0;
    end else if (state_q == S_DONE && out_ready) begin
      state_d = S_IDLE;
    end else if (state_q == S_BUSY) begin
      res_d[cnt_q*DIGIT +: DIGIT] = op_q == OP_XOR ? ca ^ cb : cs;
      carry_d = op_q != OP_XOR && cout;
      // A differing higher chunk overrides whatever the lower chunks decided.
      if (ca != cb) begin
        gt_d = cgt;
        lt_d = clt;
      end
      cnt_d = cnt_q + 1'b1;
      if (last) begin
        state_d = S_DONE;
        eq_d    = !gt_d && !lt_d;
`ifdef ALU_SAT_EN
        if (op_q == OP_ADD && carry_d) res_d = '1;
        if (op_q == OP_SUB && carry_d) res_d = '0;
`endif
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= OP_ADD;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
      eq_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      gt_q    <= gt_d;
      lt_q    <= lt_d;
      eq_q    <= eq_d;
    end
  end
endmodule
